// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared memory port and traps illegal opcodes and memory timeouts.
module multicycle_control #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op_code,
    input  logic       mem_ready,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       instr_done,
    output logic       error,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_JUMP   = 4'd12,
        S_ERROR  = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [7:0] LAST_WAIT = 8'(MEM_TIMEOUT - 1);

    state_t     cur_state;
    state_t     next_state;
    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_next;
    logic       waiting;
    logic       timed_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= S_RESET;
            wait_cnt  <= '0;
        end else begin
            cur_state <= next_state;
            wait_cnt  <= wait_cnt_next;
        end
    end

    assign waiting   = (cur_state == S_FETCH) || (cur_state == S_MEMRD) || (cur_state == S_MEMWR);
    assign timed_out = !mem_ready && (wait_cnt == LAST_WAIT);

    always_comb begin
        next_state = cur_state;
        case (cur_state)
            S_RESET:  next_state = S_FETCH;
            S_FETCH: begin
                if (mem_ready)      next_state = S_DECODE;
                else if (timed_out) next_state = S_ERROR;
            end
            S_DECODE: begin
                case (op_code)
                    OP_RTYPE:      next_state = S_EXEC;
                    OP_LW, OP_SW:  next_state = S_MEMADR;
                    OP_BEQ:        next_state = S_BRANCH;
                    OP_ADDI:       next_state = S_ADDIEX;
                    OP_J:          next_state = S_JUMP;
                    default:       next_state = S_ERROR;
                endcase
            end
            // The IR holds op_code stable, so anything but lw/sw here is a fault.
            S_MEMADR: begin
                if (op_code == OP_LW)      next_state = S_MEMRD;
                else if (op_code == OP_SW) next_state = S_MEMWR;
                else                       next_state = S_ERROR;
            end
            S_MEMRD: begin
                if (mem_ready)      next_state = S_MEMWB;
                else if (timed_out) next_state = S_ERROR;
            end
            S_MEMWR: begin
                if (mem_ready)      next_state = S_FETCH;
                else if (timed_out) next_state = S_ERROR;
            end
            S_EXEC:   next_state = S_ALUWB;
            S_ADDIEX: next_state = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: next_state = S_FETCH;
            S_ERROR:  next_state = S_ERROR;
            default:  next_state = S_ERROR;
        endcase
    end

    always_comb begin
        wait_cnt_next = '0;
        if (waiting && !mem_ready && (next_state == cur_state)) begin
            wait_cnt_next = wait_cnt + 8'd1;
        end
    end

    always_comb begin
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        instr_done    = 1'b0;
        error         = 1'b0;
        case (cur_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEMWR: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_ADDIWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_source     = 2'b01;
                pc_write_cond = 1'b1;
                instr_done    = 1'b1;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                instr_done = 1'b1;
            end
            S_ERROR: error = 1'b1;
            default: ;
        endcase
    end

    assign state = cur_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed, table-driven bench for multicycle_control: instruction sequences,
// memory stalls, timeout boundary, illegal opcode and asynchronous reset.
module tb_multicycle_control;

    logic       clk;
    logic       rst_n;
    logic [5:0] op_code;
    logic       mem_ready;
    logic       ir_write, pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, error;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;

    multicycle_control #(.MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .op_code(op_code), .mem_ready(mem_ready),
        .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .instr_done(instr_done), .error(error), .state(state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Output word layout, MSB first: ir_write .. error (18 bits).
    localparam logic [17:0] ERR   = 18'h00001;
    localparam logic [17:0] DONE  = 18'h00002;
    localparam logic [17:0] PCS01 = 18'h00004;
    localparam logic [17:0] PCS10 = 18'h00008;
    localparam logic [17:0] OP01  = 18'h00010;
    localparam logic [17:0] OP10  = 18'h00020;
    localparam logic [17:0] SB01  = 18'h00040;
    localparam logic [17:0] SB10  = 18'h00080;
    localparam logic [17:0] SB11  = 18'h000C0;
    localparam logic [17:0] SRCA  = 18'h00100;
    localparam logic [17:0] RW    = 18'h00200;
    localparam logic [17:0] RDST  = 18'h00400;
    localparam logic [17:0] M2R   = 18'h00800;
    localparam logic [17:0] MW    = 18'h01000;
    localparam logic [17:0] MR    = 18'h02000;
    localparam logic [17:0] IORD  = 18'h04000;
    localparam logic [17:0] PWC   = 18'h08000;
    localparam logic [17:0] PW    = 18'h10000;
    localparam logic [17:0] IRW   = 18'h20000;

    localparam logic [17:0] O_FETCH   = MR | SB01 | IRW | PW;
    localparam logic [17:0] O_FSTALL  = MR | SB01;
    localparam logic [17:0] O_DECODE  = SB11;
    localparam logic [17:0] O_ADR     = SRCA | SB10;
    localparam logic [17:0] O_MEMRD   = MR | IORD;
    localparam logic [17:0] O_MEMWB   = M2R | RW | DONE;
    localparam logic [17:0] O_WRWAIT  = MW | IORD;
    localparam logic [17:0] O_WRDONE  = MW | IORD | DONE;
    localparam logic [17:0] O_EXEC    = SRCA | OP10;
    localparam logic [17:0] O_ALUWB   = RDST | RW | DONE;
    localparam logic [17:0] O_ADDIWB  = RW | DONE;
    localparam logic [17:0] O_BRANCH  = SRCA | OP01 | PCS01 | PWC | DONE;
    localparam logic [17:0] O_JUMP    = PW | PCS10 | DONE;

    localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010, BAD = 6'b111111;

    typedef struct {
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [17:0] outs;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;
    int   done_cnt;

    function automatic logic [17:0] actualOutputs();
        return {ir_write, pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                pc_source, instr_done, error};
    endfunction

    function automatic void addVec(logic [5:0] op, logic rdy, logic [3:0] st, logic [17:0] outs);
        vec_t v;
        v.op = op; v.rdy = rdy; v.st = st; v.outs = outs;
        vecs.push_back(v);
    endfunction

    task automatic applyStimulus(input logic [5:0] op, input logic rdy);
        op_code   = op;
        mem_ready = rdy;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] exp_st, input logic [17:0] exp_outs);
        logic [17:0] act;
        act = actualOutputs();
        total++;
        if (state !== exp_st || act !== exp_outs) begin
            bad++;
            $display("[TB] FAIL %s: state=%0d outs=%05h, required state=%0d outs=%05h",
                     name, state, act, exp_st, exp_outs);
        end
    endtask

    task automatic runStep(input string name, input logic [5:0] op, input logic rdy,
                           input logic [3:0] st, input logic [17:0] outs);
        applyStimulus(op, rdy);
        checkOutput(name, st, outs);
        @(negedge clk);
    endtask

    // Ends one half-cycle after the release edge has moved the FSM into FETCH.
    task automatic doReset(input string name);
        rst_n = 1'b0;
        #1;
        checkOutput({name, "_async"}, 4'd0, 18'h0);
        @(negedge clk);
        checkOutput({name, "_held"}, 4'd0, 18'h0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        op_code   = RT;
        mem_ready = 1'b1;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("reset_cycle%0d", i), 4'd0, 18'h0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // R-type, lw with two MEMRD stalls, sw, beq, addi, j, then a fetch stall.
        addVec(RT, 1, 4'd1, O_FETCH);   addVec(RT, 1, 4'd2, O_DECODE);
        addVec(RT, 1, 4'd7, O_EXEC);    addVec(RT, 1, 4'd8, O_ALUWB);
        addVec(LW, 1, 4'd1, O_FETCH);   addVec(LW, 1, 4'd2, O_DECODE);
        addVec(LW, 1, 4'd3, O_ADR);     addVec(LW, 0, 4'd4, O_MEMRD);
        addVec(LW, 0, 4'd4, O_MEMRD);   addVec(LW, 1, 4'd4, O_MEMRD);
        addVec(LW, 1, 4'd5, O_MEMWB);
        addVec(SW, 1, 4'd1, O_FETCH);   addVec(SW, 1, 4'd2, O_DECODE);
        addVec(SW, 1, 4'd3, O_ADR);     addVec(SW, 1, 4'd6, O_WRDONE);
        addVec(BEQ, 1, 4'd1, O_FETCH);  addVec(BEQ, 1, 4'd2, O_DECODE);
        addVec(BEQ, 1, 4'd9, O_BRANCH);
        addVec(ADDI, 1, 4'd1, O_FETCH); addVec(ADDI, 1, 4'd2, O_DECODE);
        addVec(ADDI, 1, 4'd10, O_ADR);  addVec(ADDI, 1, 4'd11, O_ADDIWB);
        addVec(JMP, 1, 4'd1, O_FETCH);  addVec(JMP, 1, 4'd2, O_DECODE);
        addVec(JMP, 1, 4'd12, O_JUMP);
        addVec(RT, 0, 4'd1, O_FSTALL);  addVec(RT, 1, 4'd1, O_FETCH);
        addVec(RT, 1, 4'd2, O_DECODE);  addVec(RT, 1, 4'd7, O_EXEC);
        addVec(RT, 1, 4'd8, O_ALUWB);

        done_cnt = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].op, vecs[i].rdy);
            if (i < 4) done_cnt += int'(instr_done);
            checkOutput($sformatf("vec%0d", i), vecs[i].st, vecs[i].outs);
            @(negedge clk);
        end
        total++;
        if (done_cnt != 1) begin
            bad++;
            $display("[TB] FAIL rtype_done_pulses: got %0d, required 1", done_cnt);
        end

        // mem_ready on the last allowed wait cycle still completes the store.
        runStep("bnd_fetch", SW, 1, 4'd1, O_FETCH);
        runStep("bnd_decode", SW, 1, 4'd2, O_DECODE);
        runStep("bnd_adr", SW, 1, 4'd3, O_ADR);
        for (int i = 0; i < 14; i++) runStep($sformatf("bnd_wait%0d", i), SW, 0, 4'd6, O_WRWAIT);
        runStep("bnd_ready", SW, 1, 4'd6, O_WRDONE);
        runStep("bnd_next_fetch", SW, 1, 4'd1, O_FETCH);

        // Store with memory never ready: 15 MEMWR cycles then sticky ERROR.
        runStep("to_decode", SW, 1, 4'd2, O_DECODE);
        runStep("to_adr", SW, 1, 4'd3, O_ADR);
        for (int i = 0; i < 15; i++) runStep($sformatf("to_wait%0d", i), SW, 0, 4'd6, O_WRWAIT);
        for (int i = 0; i < 4; i++) runStep($sformatf("to_error%0d", i), SW, (i > 0), 4'd15, ERR);
        doReset("to_reset");
        runStep("to_refetch", RT, 1, 4'd1, O_FETCH);

        // Illegal opcode in DECODE.
        runStep("ill_decode", BAD, 1, 4'd2, O_DECODE);
        runStep("ill_error", BAD, 1, 4'd15, ERR);
        runStep("ill_hold", RT, 1, 4'd15, ERR);
        doReset("ill_reset");

        // Asynchronous reset while a store is waiting in MEMWR.
        runStep("mid_fetch", SW, 1, 4'd1, O_FETCH);
        runStep("mid_decode", SW, 1, 4'd2, O_DECODE);
        runStep("mid_adr", SW, 1, 4'd3, O_ADR);
        applyStimulus(SW, 0);
        checkOutput("mid_memwr", 4'd6, O_WRWAIT);
        #2;
        doReset("mid_reset");
        runStep("mid_refetch", RT, 1, 4'd1, O_FETCH);
        runStep("mid_redecode", RT, 1, 4'd2, O_DECODE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style control FSM that turns the MIPS datapath into a multicycle machine: one shared memory port for instructions and data, with one ALU reused for PC+4, the branch target and the execute result.
- Sequences every instruction through FETCH/DECODE/EXEC/MEM/WB cycles.
- Stalls on a memory-ready handshake and traps illegal opcodes and memory timeouts in a sticky ERROR state.
- Sits beside the main control decoder in the CPU top and drives all datapath enables and mux selects.

Parameters:
- MEM_TIMEOUT, 15, maximum number of consecutive cycles in a memory state with mem_ready=0 before the FSM enters ERROR; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- op_code  input  6  instruction[31:26], taken from the instruction register
- mem_ready  input  1  memory has completed the current read/write this cycle
- ir_write  output  1  load the instruction register
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load qualified by the ALU zero flag, done in the datapath
- i_or_d  output  1  memory address select: 0 = PC, 1 = ALU out
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- mem_to_reg  output  1  register write data: 0 = ALU out, 1 = MDR
- reg_dst  output  1  destination register: 0 = rt, 1 = rd
- reg_write  output  1  register file write enable
- alu_src_a  output  1  ALU A input: 0 = PC, 1 = rs data
- alu_src_b  output  2  ALU B input: 00 = rt data, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm<<2
- alu_op  output  2  to ALU control: 00 = add, 01 = sub, 10 = funct
- pc_source  output  2  PC source: 00 = ALU result, 01 = ALU out register, 10 = jump target
- instr_done  output  1  one-cycle pulse on the final cycle of each instruction
- error  output  1  sticky; FSM is in ERROR
- state  output  4  current state encoding, for debug

Behaviour:
- State encodings:
  - RESET=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, ADDIEX=10, ADDIWB=11, JUMP=12, ERROR=15.
  - Encodings 13 and 14 are unused and go to ERROR.
- Reset:
  - rst_n low forces state=RESET immediately and clears the wait counter.
  - In RESET every output is 0 and state is 0.
  - The first clock edge with rst_n high moves the FSM to FETCH.
- Output decode. Outputs not listed for a state are 0, including alu_src_b, alu_op and pc_source.
  - FETCH: mem_read=1, alu_src_b=01; ir_write = pc_write = mem_ready.
  - DECODE: alu_src_b=11.
  - MEMADR and ADDIEX: alu_src_a=1, alu_src_b=10.
  - MEMRD: mem_read=1, i_or_d=1.
  - MEMWR: mem_write=1, i_or_d=1, instr_done=mem_ready.
  - MEMWB: mem_to_reg=1, reg_write=1, instr_done=1.
  - EXEC: alu_src_a=1, alu_op=10.
  - ALUWB: reg_dst=1, reg_write=1, instr_done=1.
  - ADDIWB: reg_write=1, instr_done=1.
  - BRANCH: alu_src_a=1, alu_op=01, pc_source=01, pc_write_cond=1, instr_done=1.
  - JUMP: pc_write=1, pc_source=10, instr_done=1.
  - ERROR: error=1 and all other outputs 0.
- Transitions:
  - FETCH goes to DECODE when mem_ready=1, else stays.
  - DECODE decodes op_code:
    - 000000 goes to EXEC.
    - 100011 (lw) and 101011 (sw) go to MEMADR.
    - 000100 goes to BRANCH.
    - 001000 goes to ADDIEX.
    - 000010 goes to JUMP.
    - Any other opcode goes to ERROR.
  - MEMADR goes to MEMRD for lw and MEMWR for sw. op_code is re-sampled here and is held stable by the IR.
  - MEMRD goes to MEMWB when mem_ready=1, else stays.
  - MEMWR goes to FETCH when mem_ready=1, else stays.
  - EXEC goes to ALUWB. ADDIEX goes to ADDIWB.
  - MEMWB, ALUWB, ADDIWB, BRANCH and JUMP go to FETCH.
  - ERROR stays in ERROR until rst_n is asserted.
- Cycle counts per instruction, assuming mem_ready is high on the first cycle: R-type 4, lw 5, sw 4, beq 3, addi 4, j 3. Each cycle of mem_ready=0 adds one cycle.
- Timeout:
  - An 8-bit wait counter increments each cycle in FETCH, MEMRD or MEMWR with mem_ready=0.
  - It clears on any state change and whenever mem_ready=1.
  - When the counter equals MEM_TIMEOUT-1 and mem_ready=0, the next state is ERROR.
  - mem_ready=1 on that same cycle wins: the FSM makes the normal transition.
- Reset asserted mid-instruction aborts it at once. No partial write strobe extends past the reset assertion.

Test Plan:
- Reset and first fetch:
  - Stimulus: rst_n low for 3 cycles, then high; mem_ready=1.
  - Required: state=0 with all outputs 0 during reset; FETCH on the 1st edge after release, with mem_read=1, ir_write=1, pc_write=1, alu_src_b=01.
- R-type (op 000000), mem_ready=1:
  - Required state sequence: 1→2→7→8→1.
  - ALUWB asserts reg_dst=1, reg_write=1, instr_done=1.
  - Exactly one instr_done pulse over the 4 cycles.
- lw (op 100011) with mem_ready low for 2 cycles in MEMRD:
  - Required state sequence: 1,2,3,4,4,4,5,1.
  - mem_read=1 and i_or_d=1 through all three MEMRD cycles.
  - MEMWB asserts mem_to_reg=1.
- beq (op 000100) and j (op 000010):
  - beq required: BRANCH state with pc_write_cond=1, pc_source=01, alu_op=01.
  - j required: JUMP state with pc_write=1, pc_source=10.
  - Both instructions return to FETCH after 3 cycles.
- Timeout and illegal opcode:
  - Stimulus: sw with mem_ready held 0 and MEM_TIMEOUT=15.
  - Required: 15 MEMWR cycles, then ERROR, with error=1 and mem_write=0.
  - Separately, op 111111 in DECODE goes to ERROR.
  - ERROR holds under clocks and clears only on rst_n.
- Reset mid-instruction:
  - Stimulus: assert rst_n low asynchronously during MEMWR.
  - Required: mem_write drops to 0 without waiting for a clock edge and state=0. After release, the next instruction starts at FETCH.
